// File: rtl/calc_num_pkg.sv
// rtl/calc_num_pkg.sv - shared sign-magnitude / two's complement helpers
package calc_num_pkg;
  localparam logic MODE_SM2TC = 1'b0;
  localparam logic MODE_TC2SM = 1'b1;
  localparam int   MAX_W      = 64;

  // {nz, ovf, data}; data is zero-extended from the active width w
  typedef logic [MAX_W+1:0] conv_t;

  function automatic conv_t sm2tc(input logic [MAX_W-1:0] d, input int w);
    logic [MAX_W-1:0] mmask, wmask, m;
    mmask = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    wmask = {mmask[MAX_W-2:0], 1'b1};
    m     = d & mmask;
    if (!d[w-1])
      sm2tc = {2'b00, d & wmask};
    else if (m == '0)
      sm2tc = {2'b10, {MAX_W{1'b0}}};
    else
      sm2tc = {2'b00, (~m + MAX_W'(1)) & wmask};
  endfunction

  function automatic conv_t tc2sm(input logic [MAX_W-1:0] d, input int w);
    logic [MAX_W-1:0] mmask, wmask, m;
    mmask = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    wmask = {mmask[MAX_W-2:0], 1'b1};
    m     = d & mmask;
    if (!d[w-1])
      tc2sm = {2'b00, d & wmask};
    else if (m == '0)
      tc2sm = {2'b01, wmask};
    else
      tc2sm = {2'b00, ((~d + MAX_W'(1)) & mmask) | (mmask + MAX_W'(1))};
  endfunction

  function automatic conv_t calc_conv(input logic mode, input logic [MAX_W-1:0] d, input int w);
    calc_conv = (mode == MODE_SM2TC) ? sm2tc(d, w) : tc2sm(d, w);
  endfunction
endpackage

// File: rtl/sm_tc_stage.sv
// rtl/sm_tc_stage.sv - one pipeline register slice of the converter
module sm_tc_stage #(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          load_nz,
  input  logic          load_ovf,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          nz,
  output logic          ovf
);
  // payload only moves with a real word so a bubble never disturbs held data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      nz    <= 1'b0;
      ovf   <= 1'b0;
    end else if (en) begin
      valid <= load_valid;
      if (load_valid) begin
        data <= load_data;
        nz   <= load_nz;
        ovf  <= load_ovf;
      end
    end
  end
endmodule

// File: rtl/sm_tc_conv_pipe.sv
// rtl/sm_tc_conv_pipe.sv - two-stage sign-magnitude <-> two's complement converter
module sm_tc_conv_pipe
  import calc_num_pkg::*;
#(
  parameter int W     = 18,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_nz,
  output logic             out_ovf,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] evt_cnt
);
  logic         adv;
  logic         s1_valid, s1_nz, s1_ovf;
  logic [W:0]   s1_md;
  logic [1:0]   cls;
  logic [W-1:0] cvt;

  // whole pipe advances together; a stalled output freezes both slices
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // S1 classifies the range case, S2 carries the formatted word
  assign cls = 2'(calc_conv(in_mode, MAX_W'(in_data), W) >> MAX_W);
  assign cvt = W'(calc_conv(s1_md[W], MAX_W'(s1_md[W-1:0]), W));

  sm_tc_stage #(.DW(W + 1)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (adv),
    .load_valid (in_valid),
    .load_data  ({in_mode, in_data}),
    .load_nz    (cls[1]),
    .load_ovf   (cls[0]),
    .valid      (s1_valid),
    .data       (s1_md),
    .nz         (s1_nz),
    .ovf        (s1_ovf)
  );

  sm_tc_stage #(.DW(W)) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (adv),
    .load_valid (s1_valid),
    .load_data  (cvt),
    .load_nz    (s1_nz),
    .load_ovf   (s1_ovf),
    .valid      (out_valid),
    .data       (out_data),
    .nz         (out_nz),
    .ovf        (out_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      evt_cnt <= '0;
    else if (cnt_clr)
      evt_cnt <= '0;
    else if (out_valid && out_ready && (out_nz || out_ovf) && (evt_cnt != {CNT_W{1'b1}}))
      evt_cnt <= evt_cnt + CNT_W'(1);
  end
endmodule
